// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
//
// Receive-side command stage that sits between the UART receiver and the
// stopwatch/clock control FSM. Received bytes are buffered in a small FIFO,
// popped one at a time, and ASCII command characters are decoded into
// single-cycle pulses. These pulses have the same shape as the debounced
// button outputs, so the control FSM can OR the two paths together. Every
// pulse is followed by a guaranteed idle gap, which keeps back-to-back UART
// commands distinct.
//
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset; clears all state
//   i_rx_data       received byte, qualified by i_rx_done
//   i_rx_done       one-cycle strobe from the UART receiver
//   o_cmd_run_stop  one-cycle pulse for 'R' / 'r'
//   o_cmd_clear     one-cycle pulse for 'C' / 'c'
//   o_cmd_change    one-cycle pulse for 'M' / 'm'
//   o_fifo_count    FIFO occupancy, 0..DEPTH
//   o_fifo_empty    occupancy == 0
//   o_fifo_full     occupancy == DEPTH
//   o_drop_cnt      bytes dropped because the FIFO was full; saturates at 255
// -----------------------------------------------------------------------------
module uart_cmd_decoder #(
   parameter int unsigned DEPTH  = 8,  // power of two, >= 2
   parameter int unsigned ADDR_W = 3,  // log2(DEPTH)
   parameter int unsigned GAP    = 2   // cycles from a pulse until the next fetch, >= 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_done,
   output logic              o_cmd_run_stop,
   output logic              o_cmd_clear,
   output logic              o_cmd_change,
   output logic [ADDR_W:0]   o_fifo_count,
   output logic              o_fifo_empty,
   output logic              o_fifo_full,
   output logic [7:0]        o_drop_cnt
);

   // GAP-1 always fits in clog2(GAP) bits; keep at least one bit for GAP == 1.
   localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GapW-1:0] GapLoad = GapW'(GAP - 1);
   localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StGap
   } state_e;

   // ---------------------------------------------------------------------------
   // Storage and state
   // ---------------------------------------------------------------------------
   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic [7:0]        r_drop_cnt;
   logic [7:0]        r_cmd_byte;
   logic [GapW-1:0]   r_gap_cnt;
   state_e            r_state;
   logic              r_run_stop;
   logic              r_clear;
   logic              r_change;

   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_drop;
   logic              w_pop;
   logic [ADDR_W:0]   w_count_nxt;
   state_e            w_state_nxt;
   logic [GapW-1:0]   w_gap_nxt;
   logic              w_run_stop_nxt;
   logic              w_clear_nxt;
   logic              w_change_nxt;
   logic              w_match;

   // ---------------------------------------------------------------------------
   // FIFO push side
   // ---------------------------------------------------------------------------
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FullCount);

   // Full is judged on the pre-edge count, so a byte arriving while full is
   // dropped even if the pop engine frees a slot on the same edge.
   assign w_push = i_rx_done & ~w_full;
   assign w_drop = i_rx_done &  w_full;

   // Memory contents need no reset: the pointers and count define validity.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_rx_data;
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_count <= w_count_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Pop engine: IDLE fetches, ISSUE decodes, GAP enforces spacing
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_gap_nxt      = r_gap_cnt;
      w_pop          = 1'b0;
      w_run_stop_nxt = 1'b0;
      w_clear_nxt    = 1'b0;
      w_change_nxt   = 1'b0;
      w_match        = 1'b0;

      case (r_state)
         StIdle: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = StIssue;
            end
         end

         StIssue: begin
            case (r_cmd_byte)
               8'h52, 8'h72: w_run_stop_nxt = 1'b1;  // 'R' / 'r'
               8'h43, 8'h63: w_clear_nxt    = 1'b1;  // 'C' / 'c'
               8'h4D, 8'h6D: w_change_nxt   = 1'b1;  // 'M' / 'm'
               default:      ;
            endcase
            w_match = w_run_stop_nxt | w_clear_nxt | w_change_nxt;
            if (w_match) begin
               w_gap_nxt   = GapLoad;
               w_state_nxt = StGap;
            end else begin
               // Unknown bytes (CR, LF, noise) are discarded without a pulse.
               w_state_nxt = StIdle;
            end
         end

         StGap: begin
            if (r_gap_cnt != '0) begin
               w_gap_nxt = r_gap_cnt - 1'b1;
            end else begin
               w_state_nxt = StIdle;
            end
         end

         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StIdle;
         r_gap_cnt  <= '0;
         r_cmd_byte <= '0;
         r_run_stop <= 1'b0;
         r_clear    <= 1'b0;
         r_change   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_gap_cnt  <= w_gap_nxt;
         r_run_stop <= w_run_stop_nxt;
         r_clear    <= w_clear_nxt;
         r_change   <= w_change_nxt;
         // Read path is combinational from the head entry into cmd_byte.
         if (w_pop) begin
            r_cmd_byte <= r_mem[r_rd_ptr];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_cmd_run_stop = r_run_stop;
   assign o_cmd_clear    = r_clear;
   assign o_cmd_change   = r_change;
   assign o_fifo_count   = r_count;
   assign o_fifo_empty   = w_empty;
   assign o_fifo_full    = w_full;
   assign o_drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_decoder
//
// Directed self-checking bench for uart_cmd_decoder. Inputs are driven and
// outputs sampled on the falling clock edge; a monitor logs every command
// pulse with the cycle it was seen in, so pulse order and spacing can be
// compared against hand-computed schedules.
// -----------------------------------------------------------------------------
module tb_uart_cmd_decoder;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned GAP    = 2;

   localparam int unsigned KindRun = 1;
   localparam int unsigned KindClr = 2;
   localparam int unsigned KindChg = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_done = 1'b0;
   logic              cmd_run_stop;
   logic              cmd_clear;
   logic              cmd_change;
   logic [ADDR_W:0]   fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic [7:0]        drop_cnt;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned cyc = 0;
   int unsigned n_overlap = 0;
   int unsigned q_kind[$];
   int unsigned q_cyc[$];

   logic [7:0] mix_bytes [4];

   uart_cmd_decoder #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .GAP    (GAP)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_rx_data      (rx_data),
      .i_rx_done      (rx_done),
      .o_cmd_run_stop (cmd_run_stop),
      .o_cmd_clear    (cmd_clear),
      .o_cmd_change   (cmd_change),
      .o_fifo_count   (fifo_count),
      .o_fifo_empty   (fifo_empty),
      .o_fifo_full    (fifo_full),
      .o_drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: a pulse held for two cycles shows up as two entries.
   always @(negedge clk) begin
      if (cmd_run_stop) begin q_kind.push_back(KindRun); q_cyc.push_back(cyc); end
      if (cmd_clear)    begin q_kind.push_back(KindClr); q_cyc.push_back(cyc); end
      if (cmd_change)   begin q_kind.push_back(KindChg); q_cyc.push_back(cyc); end
      if ((int'(cmd_run_stop) + int'(cmd_clear) + int'(cmd_change)) > 1) n_overlap++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned qk(input int unsigned i);
      return (i < q_kind.size()) ? q_kind[i] : 99;
   endfunction

   function automatic int unsigned qc(input int unsigned i);
      return (i < q_cyc.size()) ? q_cyc[i] : 32'hFFFF_FFFF;
   endfunction

   task automatic clear_log();
      q_kind.delete();
      q_cyc.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_count"}, 32'(fifo_count), 32'd0);
      check({tag, "_empty"}, 32'(fifo_empty), 32'd1);
      check({tag, "_full"},  32'(fifo_full),  32'd0);
      check({tag, "_drop"},  32'(drop_cnt),   32'd0);
      check({tag, "_cmds"},  32'({cmd_run_stop, cmd_clear, cmd_change}), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_values("rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Watchdog so the bench can never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned t0;
      int unsigned n_bad;
      mix_bytes[0] = 8'h43;
      mix_bytes[1] = 8'h0D;
      mix_bytes[2] = 8'h4D;
      mix_bytes[3] = 8'h52;

      // ---------------- reset state ----------------
      #1;
      check_reset_values("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      while (cyc < 10) @(negedge clk);

      // ---------------- single command ----------------
      clear_log();
      t0 = cyc;
      rx_data = 8'h72;
      rx_done = 1'b1;
      @(negedge clk);                                   // N+1
      rx_done = 1'b0;
      check("single_cnt1", 32'(fifo_count), 32'd1);
      check("single_nempty", 32'(fifo_empty), 32'd0);
      @(negedge clk);                                   // N+2
      check("single_empty", 32'(fifo_empty), 32'd1);
      check("single_rs_early", 32'(cmd_run_stop), 32'd0);
      @(negedge clk);                                   // N+3
      check("single_rs", 32'(cmd_run_stop), 32'd1);
      check("single_oth", 32'({cmd_clear, cmd_change}), 32'd0);
      @(negedge clk);                                   // N+4
      check("single_rs_off", 32'(cmd_run_stop), 32'd0);
      repeat (4) @(negedge clk);
      check("single_npulse", q_kind.size(), 32'd1);
      check("single_pcyc", qc(0), t0 + 3);

      // ---------------- back-to-back mix ----------------
      clear_log();
      t0 = cyc;
      for (int i = 0; i < 4; i++) begin
         rx_data = mix_bytes[i];
         rx_done = 1'b1;
         @(negedge clk);
      end
      rx_done = 1'b0;
      while (cyc < t0 + 20) @(negedge clk);
      check("mix_npulse", q_kind.size(), 32'd3);
      check("mix_k0", qk(0), KindClr);
      check("mix_k1", qk(1), KindChg);
      check("mix_k2", qk(2), KindRun);
      check("mix_c0", qc(0), t0 + 3);
      check("mix_c1", qc(1), t0 + 9);
      check("mix_c2", qc(2), t0 + 13);

      // ---------------- overflow ----------------
      clear_log();
      t0 = cyc;
      for (int i = 0; i < 12; i++) begin
         if (i == 10) check("ovf_notfull", 32'(fifo_full), 32'd0);
         if (i == 11) begin
            check("ovf_full", 32'(fifo_full), 32'd1);
            check("ovf_cnt8", 32'(fifo_count), 32'd8);
         end
         rx_data = 8'h63;
         rx_done = 1'b1;
         @(negedge clk);
      end
      rx_done = 1'b0;
      check("ovf_drop_now", 32'(drop_cnt), 32'd1);
      for (int i = 0; i < 100 && q_kind.size() < 11; i++) @(negedge clk);
      repeat (6) @(negedge clk);
      check("ovf_npulse", q_kind.size(), 32'd11);
      n_bad = 0;
      foreach (q_kind[i]) if (q_kind[i] != KindClr) n_bad++;
      check("ovf_kinds", n_bad, 32'd0);
      check("ovf_drop", 32'(drop_cnt), 32'd1);
      check("ovf_cnt0", 32'(fifo_count), 32'd0);

      // ---------------- drop counter saturation ----------------
      do_reset();
      clear_log();
      t0 = cyc;
      rx_data = 8'h63;
      rx_done = 1'b1;
      repeat (20) @(negedge clk);
      // Drops at offsets 11,12,13,15,16,17,19 while one slot frees every 4 cycles.
      check("sat_drop7", 32'(drop_cnt), 32'd7);
      repeat (480) @(negedge clk);
      rx_done = 1'b0;
      check("sat_drop255", 32'(drop_cnt), 32'd255);
      for (int i = 0; i < 100 && !fifo_empty; i++) @(negedge clk);
      repeat (6) @(negedge clk);
      check("sat_hold", 32'(drop_cnt), 32'd255);
      check("sat_drained", 32'(fifo_empty), 32'd1);

      // ---------------- reset mid-operation ----------------
      clear_log();
      t0 = cyc;
      rx_data = 8'h52;
      rx_done = 1'b1;
      @(negedge clk);
      rx_data = 8'h43;
      @(negedge clk);                                   // t0+2
      rx_done = 1'b0;
      @(negedge clk);                                   // t0+3
      check("mid_rs", 32'(cmd_run_stop), 32'd1);
      @(negedge clk);                                   // t0+4
      check("mid_pending", 32'(fifo_count), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_async");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("mid_npulse", q_kind.size(), 32'd1);
      check("mid_k0", qk(0), KindRun);
      check("mid_cnt0", 32'(fifo_count), 32'd0);
      check("mid_drop0", 32'(drop_cnt), 32'd0);

      // ---------------- pointer wrap ----------------
      clear_log();
      t0 = cyc;
      for (int i = 0; i < 20; i++) begin
         check("wrap_occ", 32'(fifo_count), 32'd0);
         rx_data = (i % 2 == 0) ? 8'h6D : 8'h72;
         rx_done = 1'b1;
         @(negedge clk);
         rx_done = 1'b0;
         repeat (3) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      check("wrap_npulse", q_kind.size(), 32'd20);
      for (int i = 0; i < 20; i++) begin
         check("wrap_kind", qk(i), (i % 2 == 0) ? KindChg : KindRun);
         check("wrap_cyc", qc(i), t0 + 4 * i + 3);
      end
      check("wrap_cnt0", 32'(fifo_count), 32'd0);

      check("overlap", n_overlap, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Receive-side command stage between the UART receiver and the stopwatch/clock control FSM. Buffers received bytes in a small FIFO, pops them one at a time, and decodes ASCII command characters into single-cycle pulses. The pulses have the same shape as the debounced button outputs, so the FSM can OR them with the button path. Each pulse is separated by a guaranteed idle gap, which keeps back-to-back UART commands distinct.

## Interface
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- ADDR_W, 3: log2(DEPTH).
- GAP, 2: cycles from a command pulse until the pop engine may fetch again; minimum 1.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; clears all state.
- rx_data  in  8  received byte; valid only in a cycle where rx_done=1.
- rx_done  in  1  one-cycle strobe from the UART receiver.
- cmd_run_stop  out  1  one-cycle pulse for 'R'/'r'.
- cmd_clear  out  1  one-cycle pulse for 'C'/'c'.
- cmd_change  out  1  one-cycle pulse for 'M'/'m'.
- fifo_count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- fifo_empty  out  1  fifo_count==0.
- fifo_full  out  1  fifo_count==DEPTH.
- drop_cnt  out  8  count of bytes dropped on a full FIFO; saturates at 255.

## Operation
- **Push.** On a clk edge with rx_done=1 and fifo_full=0, write rx_data to mem[wr_ptr] and increment wr_ptr (wraps modulo DEPTH).
  - fifo_full is evaluated on the pre-edge count. A byte arriving while full is dropped, even if a pop occurs on the same edge.
  - Each dropped byte increments drop_cnt, saturating at 255. drop_cnt is cleared only by reset.
- **Pop engine.** The state machine has three states: IDLE, ISSUE, GAP.
  - IDLE: if fifo_empty=0, on the edge latch cmd_byte<=mem[rd_ptr], increment rd_ptr (wraps), and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: decode cmd_byte.
    - 0x52/0x72 sets cmd_run_stop; 0x43/0x63 sets cmd_clear; 0x4D/0x6D sets cmd_change.
    - On a match: register the pulse, load the gap counter with GAP-1, and go to GAP.
    - Any other byte (including CR/LF) is discarded: no pulse, go directly to IDLE.
  - GAP: while the counter is nonzero, decrement it. At zero, go to IDLE.
- **Pulse outputs.** Outputs are registered and high for exactly one cycle, which is the first GAP cycle. At most one cmd_* output is high in any cycle.
- **Occupancy.** A push alone gives count+1, a pop alone gives count-1, and a push and pop on the same edge leave the count unchanged. A pop is never attempted when empty.
- **Reset.** When reset is low at any time, including mid-command:
  - Pointers, count, cmd_byte and drop_cnt are cleared, and the state returns to IDLE.
  - All cmd_* outputs go to 0, fifo_empty=1, fifo_full=0, fifo_count=0.
  - Pending bytes are lost and no pulse is emitted after release.

## Timing
- rx_done high in cycle N with an empty FIFO and IDLE state:
  - fifo_count=1 in N+1.
  - Byte latched at the end of N+1 (ISSUE in N+2).
  - Command pulse high in cycle N+3 only.
  - Latency is 3 cycles.
- Consecutive valid commands already in the FIFO produce pulses spaced GAP+2 cycles apart (4 with the default GAP).
- Invalid bytes consume 2 cycles each (IDLE→ISSUE→IDLE) and produce no pulse.
- A push is accepted on every cycle rx_done=1 while not full. There is no back-pressure to the UART.
- Memory is written on the clock edge. The read path is combinational from mem[rd_ptr] into the cmd_byte register.

## Test plan
- **Single command.** Reset, release, then rx_done with rx_data=0x72 at cycle 10.
  - fifo_count=1 at cycle 11.
  - cmd_run_stop=1 at cycle 13 only; other cmd_* stay 0.
  - fifo_empty=1 again from cycle 12.
- **Back-to-back mix.** Push 0x43, 0x0D, 0x4D, 0x52 on consecutive cycles (rx_done cycles 10–13).
  - Expect cmd_clear pulse, then cmd_change pulse, then cmd_run_stop pulse, in that order.
  - The 0x0D adds 2 cycles before the cmd_change pulse.
  - Spacing is 4 cycles between cmd_change and cmd_run_stop.
  - No overlapping pulses.
- **Overflow.** Push 12 bytes of 0x63 on consecutive cycles, with the FIFO starting empty and DEPTH=8.
  - fifo_full asserts as soon as occupancy reaches 8.
  - drop_cnt increments on every later push that arrives while fifo_full=1; after the FIFO drains, drop_cnt equals the number of bytes minus the number of cmd_clear pulses.
  - Every accepted byte produces exactly one cmd_clear pulse.
- **Drop counter saturation.** Hold the pop engine busy with 8 valid bytes in the FIFO, then push 300 further bytes while fifo_full=1.
  - drop_cnt stops at 255 and does not wrap.
- **Reset mid-operation.** Push 0x52 then 0x43; assert reset low in the cycle after the cmd_run_stop pulse, hold 3 cycles, release.
  - Outputs reach reset values immediately (asynchronous).
  - No cmd_clear pulse follows; fifo_count=0 and drop_cnt=0.
- **Pointer wrap.** Run 20 push/pop cycles of alternating 0x6D and 0x72 with occupancy ≤3.
  - Pulses follow push order exactly across the wr_ptr/rd_ptr wrap.
  - fifo_count returns to 0.
